// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its datapath/host: program/init loading, start, and issued words.
// master = sequencer side, slave = host/datapath side.
interface instr_sequencer_if #(
    parameter int PCW = 4
);
    logic           start;
    logic           prog_we;
    logic [PCW-1:0] prog_addr;
    logic [15:0]    prog_wdata;
    logic           init_we;
    logic [3:0]     init_addr;
    logic [15:0]    init_wdata;
    logic [15:0]    Instruction;
    logic [15:0]    DataInit;
    logic           InitSel;
    logic           busy;
    logic           done;
    logic [PCW-1:0] pc;

    modport master (
        input  start, prog_we, prog_addr, prog_wdata, init_we, init_addr, init_wdata,
        output Instruction, DataInit, InitSel, busy, done, pc
    );

    modport slave (
        output start, prog_we, prog_addr, prog_wdata, init_we, init_addr, init_wdata,
        input  Instruction, DataInit, InitSel, busy, done, pc
    );
endinterface

// File: rtl/instr_sequencer.sv
// Issues one init write per register, then streams program words one per clk until HALT or end of memory.
// Outputs registered; loads are only accepted while not busy; start is ignored while busy.
module instr_sequencer #(
    parameter int          PROG_DEPTH  = 16,
    parameter int          INIT_REGS   = 16,
    parameter logic [3:0]  INIT_OPCODE = 4'h0,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'hF000
) (
    input logic               clk,
    input logic               reset,
    instr_sequencer_if.master bus
);
    localparam int PCW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic [15:0]    r_prog [PROG_DEPTH];
    logic [15:0]    r_init [16];
    logic [15:0]    r_instr;
    logic [15:0]    r_data;
    logic           r_initsel;
    logic [PCW-1:0] r_pc;
    logic [3:0]     r_idx;

    logic           w_loadable;
    logic [PCW-1:0] w_pc_nxt;
    logic [3:0]     w_idx_nxt;
    logic [15:0]    w_prog_nxt;
    logic [15:0]    w_prog_first;

    assign w_loadable   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_pc_nxt     = r_pc + PCW'(1);
    assign w_idx_nxt    = r_idx + 4'd1;
    assign w_prog_nxt   = r_prog[w_pc_nxt];
    assign w_prog_first = r_prog[0];

    // Memories are deliberately left out of reset so a reset does not lose a loaded program.
    always_ff @(posedge clk) begin
        if (!reset && w_loadable) begin
            if (bus.prog_we && (int'(bus.prog_addr) < PROG_DEPTH))
                r_prog[bus.prog_addr] <= bus.prog_wdata;
            if (bus.init_we)
                r_init[bus.init_addr] <= bus.init_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_instr   <= NOP_INSTR;
            r_data    <= 16'h0000;
            r_initsel <= 1'b1;
            r_pc      <= '0;
            r_idx     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state   <= S_INIT;
                        r_instr   <= {INIT_OPCODE, 4'd0, 8'h00};
                        r_data    <= r_init[0];
                        r_initsel <= 1'b0;
                        r_idx     <= 4'd0;
                        r_pc      <= '0;
                    end
                end
                S_INIT: begin
                    if (r_idx == 4'(INIT_REGS - 1)) begin
                        r_data    <= 16'h0000;
                        r_initsel <= 1'b1;
                        r_pc      <= '0;
                        // A HALT in word 0 means an empty program: never issue it.
                        if (w_prog_first[15:12] == HALT_OPCODE) begin
                            r_state <= S_DONE;
                            r_instr <= NOP_INSTR;
                        end else begin
                            r_state <= S_RUN;
                            r_instr <= w_prog_first;
                        end
                    end else begin
                        r_idx  <= w_idx_nxt;
                        r_instr <= {INIT_OPCODE, w_idx_nxt, 8'h00};
                        r_data <= r_init[w_idx_nxt];
                    end
                end
                S_RUN: begin
                    r_data <= 16'h0000;
                    if ((r_pc == PCW'(PROG_DEPTH - 1)) || (w_prog_nxt[15:12] == HALT_OPCODE)) begin
                        r_state <= S_DONE;
                        r_instr <= NOP_INSTR;
                    end else begin
                        r_pc    <= w_pc_nxt;
                        r_instr <= w_prog_nxt;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_instr <= NOP_INSTR;
                end
            endcase
        end
    end

    assign bus.Instruction = r_instr;
    assign bus.DataInit    = r_data;
    assign bus.InitSel     = r_initsel;
    assign bus.pc          = r_pc;
    assign bus.busy        = (r_state == S_INIT) || (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
endmodule
